// File: rtl/atmega_io_pkg.sv
// Shared I/O-space constants for ATmega-compatible peripherals.
// Default register addresses and control/status bit positions.
package atmega_io_pkg;
  localparam int PORT_OUT_ADDR_DEF   = 'h25;
  localparam int DDR_ADDR_DEF        = 'h24;
  localparam int PIN_ADDR_DEF        = 'h23;
  localparam int PORT_CLEAR_ADDR_DEF = 'h00;
  localparam int PORT_SET_ADDR_DEF   = 'h01;
  localparam int PCMSK_ADDR_DEF      = 'h6B;
  localparam int PCCTRL_ADDR_DEF     = 'h3B;

  localparam int PCIE_BIT = 0;
  localparam int PCIF_BIT = 1;
endpackage

// File: rtl/atmega_sync2.sv
// Two-flop synchroniser for asynchronous inputs; 2-cycle latency, no backpressure.
module atmega_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= '0;
      q  <= '0;
    end else begin
      s0 <= d;
      q  <= s0;
    end
  end
endmodule

// File: rtl/atmega_pio_pcint.sv
// GPIO port with PIN toggle, optional PORT clear/set and a pin-change interrupt.
// Reads are combinational; writes take effect on the next edge; no backpressure.
module atmega_pio_pcint
  import atmega_io_pkg::*;
#(
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter int                           PORT_WIDTH        = 8,
  parameter string                        USE_CLEAR_SET     = "FALSE",
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PORT_OUT_ADDR     = BUS_ADDR_DATA_LEN'(PORT_OUT_ADDR_DEF),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] DDR_ADDR          = BUS_ADDR_DATA_LEN'(DDR_ADDR_DEF),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PIN_ADDR          = BUS_ADDR_DATA_LEN'(PIN_ADDR_DEF),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PORT_CLEAR_ADDR   = BUS_ADDR_DATA_LEN'(PORT_CLEAR_ADDR_DEF),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PORT_SET_ADDR     = BUS_ADDR_DATA_LEN'(PORT_SET_ADDR_DEF),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PCMSK_ADDR        = BUS_ADDR_DATA_LEN'(PCMSK_ADDR_DEF),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PCCTRL_ADDR       = BUS_ADDR_DATA_LEN'(PCCTRL_ADDR_DEF),
  parameter logic [7:0]                   PINMASK           = 8'hFF,
  parameter logic [7:0]                   PULLUP_MASK       = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [7:0]                   bus_dat_in,
  output logic [7:0]                   bus_dat_out,
  input  logic [PORT_WIDTH-1:0]        io_in,
  output logic [PORT_WIDTH-1:0]        io_out,
  output logic [PORT_WIDTH-1:0]        io_oe,
  output logic [PORT_WIDTH-1:0]        io_pullup,
  output logic                         irq,
  input  logic                         irq_ack
);
  localparam int             W     = PORT_WIDTH;
  localparam bit             CS_EN = (USE_CLEAR_SET == "TRUE");
  localparam logic [W-1:0]   PIN_M = PINMASK[W-1:0];
  localparam logic [W-1:0]   PU_M  = PULLUP_MASK[W-1:0];

  logic [W-1:0] ddr_q, port_q, pcmsk_q, pin_prev_q;
  logic [W-1:0] sync_q, pin_val, change, wdat, port_nxt;
  logic         pcie_q, pcif_q;
  logic         we_port, we_ddr, we_pin, we_clr, we_set, we_pcmsk, we_ctrl;
  logic         pcif_set, pcif_clr;
  logic [7:0]   rd_word;

  atmega_sync2 #(.WIDTH(W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io_in),
    .q   (sync_q)
  );

  assign pin_val = sync_q & PIN_M;
  assign wdat    = bus_dat_in[W-1:0];

  assign we_port  = wr_dat && (addr_dat == PORT_OUT_ADDR);
  assign we_ddr   = wr_dat && (addr_dat == DDR_ADDR);
  assign we_pin   = wr_dat && (addr_dat == PIN_ADDR);
  assign we_clr   = CS_EN && wr_dat && (addr_dat == PORT_CLEAR_ADDR);
  assign we_set   = CS_EN && wr_dat && (addr_dat == PORT_SET_ADDR);
  assign we_pcmsk = wr_dat && (addr_dat == PCMSK_ADDR);
  assign we_ctrl  = wr_dat && (addr_dat == PCCTRL_ADDR);

  always_comb begin
    port_nxt = port_q;
    if (we_port)     port_nxt = wdat;
    else if (we_pin) port_nxt = port_q ^ wdat;
    else if (we_clr) port_nxt = port_q & ~wdat;
    else if (we_set) port_nxt = port_q | wdat;
  end

  // Both edges count; absent and unmasked pins are filtered out.
  assign change   = (sync_q ^ pin_prev_q) & pcmsk_q & PIN_M;
  assign pcif_set = |change;
  assign pcif_clr = irq_ack || (we_ctrl && bus_dat_in[PCIF_BIT]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ddr_q      <= '0;
      port_q     <= '0;
      pcmsk_q    <= '0;
      pin_prev_q <= '0;
      pcie_q     <= 1'b0;
      pcif_q     <= 1'b0;
    end else begin
      port_q     <= port_nxt;
      pin_prev_q <= sync_q;
      if (we_ddr)   ddr_q   <= wdat;
      if (we_pcmsk) pcmsk_q <= wdat;
      if (we_ctrl)  pcie_q  <= bus_dat_in[PCIE_BIT];
      // A new change outranks a simultaneous acknowledge or write-1-clear.
      if (pcif_set)      pcif_q <= 1'b1;
      else if (pcif_clr) pcif_q <= 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_dat) begin
      if (addr_dat == PORT_OUT_ADDR)    rd_word[W-1:0] = port_q;
      else if (addr_dat == DDR_ADDR)    rd_word[W-1:0] = ddr_q;
      else if (addr_dat == PIN_ADDR)    rd_word[W-1:0] = pin_val;
      else if (addr_dat == PCMSK_ADDR)  rd_word[W-1:0] = pcmsk_q;
      else if (addr_dat == PCCTRL_ADDR) begin
        rd_word[PCIE_BIT] = pcie_q;
        rd_word[PCIF_BIT] = pcif_q;
      end
    end
  end

  assign bus_dat_out = rd_word;
  assign io_out      = ddr_q & port_q;
  assign io_oe       = ddr_q;
  assign io_pullup   = ~ddr_q & port_q & PU_M;
  assign irq         = pcif_q & pcie_q;
endmodule

// File: tb/tb_atmega_pio_pcint.sv
// Bench for atmega_pio_pcint: three instances (8-bit with clear/set, 8-bit without, 4-bit narrow)
// share one bus and pad stimulus; expectations go through a scoreboard queue.
module tb_atmega_pio_pcint;
  localparam logic [7:0] A_PORT  = 8'h25;
  localparam logic [7:0] A_DDR   = 8'h24;
  localparam logic [7:0] A_PIN   = 8'h23;
  localparam logic [7:0] A_CLR   = 8'h00;
  localparam logic [7:0] A_SET   = 8'h01;
  localparam logic [7:0] A_PCMSK = 8'h6B;
  localparam logic [7:0] A_CTRL  = 8'h3B;
  localparam logic [7:0] A_NONE  = 8'h50;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr_dat, bus_dat_in, io_in;
  logic       wr_dat, rd_dat, irq_ack;

  logic [7:0] a_dout, a_out, a_oe, a_pu;
  logic [7:0] b_dout, b_out, b_oe, b_pu;
  logic [7:0] c_dout;
  logic [3:0] c_out, c_oe, c_pu;
  logic       a_irq, b_irq, c_irq;

  always #5 clk = ~clk;

  atmega_pio_pcint #(.USE_CLEAR_SET("TRUE")) u_pio_cs (
    .clk(clk), .rst(rst), .addr_dat(addr_dat), .wr_dat(wr_dat), .rd_dat(rd_dat),
    .bus_dat_in(bus_dat_in), .bus_dat_out(a_dout), .io_in(io_in), .io_out(a_out),
    .io_oe(a_oe), .io_pullup(a_pu), .irq(a_irq), .irq_ack(irq_ack)
  );

  atmega_pio_pcint u_pio_nocs (
    .clk(clk), .rst(rst), .addr_dat(addr_dat), .wr_dat(wr_dat), .rd_dat(rd_dat),
    .bus_dat_in(bus_dat_in), .bus_dat_out(b_dout), .io_in(io_in), .io_out(b_out),
    .io_oe(b_oe), .io_pullup(b_pu), .irq(b_irq), .irq_ack(irq_ack)
  );

  atmega_pio_pcint #(.PORT_WIDTH(4), .PINMASK(8'h0F), .PULLUP_MASK(8'h00), .USE_CLEAR_SET("TRUE")) u_pio_nar (
    .clk(clk), .rst(rst), .addr_dat(addr_dat), .wr_dat(wr_dat), .rd_dat(rd_dat),
    .bus_dat_in(bus_dat_in), .bus_dat_out(c_dout), .io_in(io_in[3:0]), .io_out(c_out),
    .io_oe(c_oe), .io_pullup(c_pu), .irq(c_irq), .irq_ack(irq_ack)
  );

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h", tag, got, want);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    sb_q.push_back('{tag: {tag, "/cs"},   val: e0});
    sb_q.push_back('{tag: {tag, "/nocs"}, val: e1});
    sb_q.push_back('{tag: {tag, "/nar"},  val: e2});
  endtask

  task automatic sb_pop(input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2);
    exp_t e;
    e = sb_q.pop_front(); check_eq(e.tag, o0, e.val);
    e = sb_q.pop_front(); check_eq(e.tag, o1, e.val);
    e = sb_q.pop_front(); check_eq(e.tag, o2, e.val);
  endtask

  // sel: 0 io_out, 1 io_oe, 2 io_pullup, 3 irq, 4 bus_dat_out
  task automatic check3(input string tag, input int sel, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] o0, o1, o2;
    sb_push(tag, e0, e1, e2);
    o0 = '0; o1 = '0; o2 = '0;
    case (sel)
      0: begin o0 = a_out; o1 = b_out; o2 = {4'h0, c_out}; end
      1: begin o0 = a_oe;  o1 = b_oe;  o2 = {4'h0, c_oe};  end
      2: begin o0 = a_pu;  o1 = b_pu;  o2 = {4'h0, c_pu};  end
      3: begin o0 = {7'h0, a_irq}; o1 = {7'h0, b_irq}; o2 = {7'h0, c_irq}; end
      default: begin o0 = a_dout; o1 = b_dout; o2 = c_dout; end
    endcase
    sb_pop(o0, o1, o2);
  endtask

  task automatic rd3(input string tag, input logic [7:0] a, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    @(negedge clk);
    addr_dat = a;
    rd_dat   = 1'b1;
    #1;
    check3(tag, 4, e0, e1, e2);
    rd_dat = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_dat   = a;
    bus_dat_in = d;
    wr_dat     = 1'b1;
    @(posedge clk);
    #1;
    wr_dat = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_dat = '0; bus_dat_in = '0; wr_dat = 1'b0; rd_dat = 1'b0;
    irq_ack = 1'b0; io_in = 8'hFF; rst = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check3("rst_out", 0, 8'h00, 8'h00, 8'h00);
    check3("rst_oe",  1, 8'h00, 8'h00, 8'h00);
    check3("rst_pu",  2, 8'h00, 8'h00, 8'h00);
    check3("rst_irq", 3, 8'h00, 8'h00, 8'h00);
    rd3("rst_pin",  A_PIN,  8'h00, 8'h00, 8'h00);
    rd3("rst_ctrl", A_CTRL, 8'h00, 8'h00, 8'h00);

    @(negedge clk);
    rst = 1'b1;
    rd3("pin_edge1", A_PIN, 8'h00, 8'h00, 8'h00);
    rd3("pin_edge2", A_PIN, 8'hFF, 8'hFF, 8'h0F);

    wr(A_DDR, 8'h0F);
    wr(A_PORT, 8'h5A);
    check3("dir_out", 0, 8'h0A, 8'h0A, 8'h0A);
    check3("dir_oe",  1, 8'h0F, 8'h0F, 8'h0F);
    check3("dir_pu",  2, 8'h50, 8'h50, 8'h00);
    wr(A_PIN, 8'hFF);
    rd3("pin_toggle", A_PORT, 8'hA5, 8'hA5, 8'h05);

    wr(A_PORT, 8'hF0);
    wr(A_CLR, 8'h30);
    rd3("port_clr", A_PORT, 8'hC0, 8'hF0, 8'h00);
    wr(A_SET, 8'h03);
    rd3("port_set", A_PORT, 8'hC3, 8'hF0, 8'h03);
    rd3("clr_noread", A_CLR, 8'h00, 8'h00, 8'h00);

    wr(A_PORT, 8'hFF);
    rd3("wide_port", A_PORT, 8'hFF, 8'hFF, 8'h0F);
    rd3("wide_pin",  A_PIN,  8'hFF, 8'hFF, 8'h0F);
    rd3("unmapped",  A_NONE, 8'h00, 8'h00, 8'h00);
    rd3("ddr_rd",    A_DDR,  8'h0F, 8'h0F, 8'h0F);

    wr(A_PCMSK, 8'h04);
    wr(A_CTRL, 8'h01);
    rd3("ctrl_en",  A_CTRL,  8'h01, 8'h01, 8'h01);
    rd3("pcmsk_rd", A_PCMSK, 8'h04, 8'h04, 8'h04);

    @(negedge clk); io_in[3] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check3("masked_pin", 3, 8'h00, 8'h00, 8'h00);
    rd3("masked_ctrl", A_CTRL, 8'h01, 8'h01, 8'h01);

    @(negedge clk); io_in[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check3("irq_edge2", 3, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check3("irq_edge3", 3, 8'h01, 8'h01, 8'h01);
    rd3("flag_ctrl", A_CTRL, 8'h03, 8'h03, 8'h03);
    wr(A_CTRL, 8'h03);
    check3("w1c_irq", 3, 8'h00, 8'h00, 8'h00);
    rd3("w1c_ctrl", A_CTRL, 8'h01, 8'h01, 8'h01);

    @(negedge clk); io_in[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1; irq_ack = 1'b1;
    @(posedge clk);
    #1;
    check3("coll_ack", 3, 8'h01, 8'h01, 8'h01);
    @(posedge clk);
    #1; irq_ack = 1'b0;
    check3("ack_clr", 3, 8'h00, 8'h00, 8'h00);

    @(negedge clk); io_in[2] = 1'b0;
    repeat (2) @(posedge clk);
    wr(A_CTRL, 8'h03);
    check3("coll_w1c", 3, 8'h01, 8'h01, 8'h01);
    wr(A_CTRL, 8'h03);
    check3("w1c_again", 3, 8'h00, 8'h00, 8'h00);

    wr(A_CTRL, 8'h00);
    @(negedge clk); io_in[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check3("pcie_off_irq", 3, 8'h00, 8'h00, 8'h00);
    rd3("pcie_off_ctrl", A_CTRL, 8'h02, 8'h02, 8'h02);
    wr(A_CTRL, 8'h02);
    rd3("pcie_off_clr", A_CTRL, 8'h00, 8'h00, 8'h00);

    wr(A_PCMSK, 8'hFF);
    rd3("pcmsk_wide", A_PCMSK, 8'hFF, 8'hFF, 8'h0F);
    @(negedge clk); io_in[6] = 1'b0;
    repeat (4) @(posedge clk);
    rd3("absent_pin", A_CTRL, 8'h02, 8'h02, 8'h00);

    wr(A_CTRL, 8'h01);
    check3("pre_rst_irq", 3, 8'h01, 8'h01, 8'h00);
    @(negedge clk); rst = 1'b0;
    #1;
    check3("mid_rst_irq", 3, 8'h00, 8'h00, 8'h00);
    check3("mid_rst_out", 0, 8'h00, 8'h00, 8'h00);
    rd3("mid_rst_ctrl", A_CTRL, 8'h00, 8'h00, 8'h00);
    rd3("mid_rst_port", A_PORT, 8'h00, 8'h00, 8'h00);

    check_eq("sb_left", 8'(sb_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/atmega_pio_pcint.md
Name: atmega_pio_pcint

Overview:
- Parametrised GPIO port for the ATmega-compatible core, successor to the basic PIO.
- Adds a 2-flop input synchroniser, PIN-write toggle, optional PORT clear/set strobes, pull-up and output-enable outputs, and a per-port pin-change interrupt (mask, flag, enable, vector acknowledge).
- Sits on the I/O data bus beside the other peripherals; its IRQ goes to the interrupt controller.

Parameters:
- BUS_ADDR_DATA_LEN, 8, width of addr_dat.
- PORT_WIDTH, 8, number of pins, 1..8; bus data is always 8 bits, unused upper bits read 0 and are ignored on write.
- USE_CLEAR_SET, "FALSE", "TRUE" enables the PORT clear/set addresses.
- PORT_OUT_ADDR, 'h25, PORT register address.
- DDR_ADDR, 'h24, DDR register address.
- PIN_ADDR, 'h23, PIN read and toggle-write address.
- PORT_CLEAR_ADDR, 'h00, write-1-clear PORT address (USE_CLEAR_SET only).
- PORT_SET_ADDR, 'h01, write-1-set PORT address (USE_CLEAR_SET only).
- PCMSK_ADDR, 'h6B, pin-change mask register address.
- PCCTRL_ADDR, 'h3B, control/status register address: bit0 PCIE, bit1 PCIF.
- PINMASK, 8'hFF, physically present pins; absent bits read 0 and never flag a change.
- PULLUP_MASK, 8'hFF, pins allowed to drive io_pullup.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- addr_dat, input, BUS_ADDR_DATA_LEN, I/O address.
- wr_dat, input, 1, write strobe, one cycle per write.
- rd_dat, input, 1, read strobe.
- bus_dat_in, input, 8, write data.
- bus_dat_out, output, 8, read data; combinational.
- io_in, input, PORT_WIDTH, asynchronous pad inputs.
- io_out, output, PORT_WIDTH, pad output value.
- io_oe, output, PORT_WIDTH, pad output enable (= DDR).
- io_pullup, output, PORT_WIDTH, pull-up request.
- irq, output, 1, pin-change interrupt request, level.
- irq_ack, input, 1, vector-taken pulse from the interrupt controller.

Behaviour:

Reset (rst = 0, asynchronous):
- DDR, PORT, PCMSK, PCIE, PCIF, sync0, sync1 and pin_prev all clear to 0.
- Outputs: io_out = 0, io_oe = 0, io_pullup = 0, irq = 0, bus_dat_out = 0.
- Reset mid-operation aborts any pending flag.

Outputs:
- io_out[i] = DDR[i] & PORT[i].
- io_pullup[i] = ~DDR[i] & PORT[i] & PULLUP_MASK[i].

Synchroniser and PIN read:
- sync0 <= io_in; sync1 <= sync0.
- PIN reads sync1 & PINMASK, so a pad change is visible on the 2nd rising edge after it occurs.

Writes (one per cycle, decoded by addr_dat when wr_dat = 1):
- PORT_OUT_ADDR: PORT <= data.
- DDR_ADDR: DDR <= data.
- PIN_ADDR: PORT <= PORT ^ data (toggle).
- PORT_CLEAR_ADDR: PORT <= PORT & ~data (USE_CLEAR_SET only).
- PORT_SET_ADDR: PORT <= PORT | data (USE_CLEAR_SET only).
- PCMSK_ADDR: PCMSK <= data.
- PCCTRL_ADDR: PCIE <= data[0]; PCIF cleared if data[1] = 1.
- With USE_CLEAR_SET = "FALSE", the clear/set addresses are not decoded.

Reads (rd_dat = 1, combinational, same cycle):
- PORT, DDR, PIN, PCMSK and PCCTRL = {6'b0, PCIF, PCIE}.
- Any other address, or rd_dat = 0, returns 0.

Pin-change detection:
- pin_prev <= sync1 every cycle.
- change = (sync1 ^ pin_prev) & PCMSK & PINMASK.
- Any bit of change set causes PCIF <= 1 on the next edge.
- Rising and falling edges both count.
- PCIF is independent of PCIE and DDR; an output pin toggling its pad still flags.

Interrupt:
- irq = PCIF & PCIE, combinational from registers.
- irq_ack = 1 clears PCIF.
- Priority: a set in the same cycle as a clear (ack or write-1) wins; PCIF remains 1.

Boundaries:
- PORT_WIDTH < 8: upper bus bits are ignored on write and read 0.
- Pins with PINMASK = 0 read 0 and never set PCIF.

Decomposition:
- Shared package atmega_io_pkg: default I/O address constants, PCCTRL bit indices (PCIE = 0, PCIF = 1).
- One sub-module, atmega_sync2: parametrised-width 2-flop synchroniser with async active-low reset. It is reused by other input peripherals.

Test Plan:
- Reset/defaults: hold rst = 0 with io_in = 8'hFF -> io_out = 0, io_oe = 0, irq = 0, all reads 0; after release, PIN reads 8'hFF two cycles later.
- Direction/pull-up: DDR = 8'h0F, PORT = 8'h5A -> io_out = 8'h0A, io_oe = 8'h0F, io_pullup = 8'h50; PIN write 8'hFF -> PORT reads 8'hA5.
- Clear/set (USE_CLEAR_SET = "TRUE"): PORT = 8'hF0; write 8'h30 to PORT_CLEAR_ADDR -> 8'hC0; write 8'h03 to PORT_SET_ADDR -> 8'hC3. With "FALSE", the same writes leave PORT unchanged.
- Pin change: PCMSK = 8'h04, PCIE = 1.
  - Toggle io_in[3] -> no PCIF.
  - Toggle io_in[2] -> PCIF = 1 and irq = 1 exactly 3 edges after the toggle.
  - Write PCCTRL 8'h03 -> PCIF = 0, irq = 0.
- Collision: change detected in the same cycle as irq_ack -> PCIF stays 1. Ack alone in the next cycle -> PCIF = 0.
- Narrow port: PORT_WIDTH = 4, PINMASK = 8'h0F, io_in = 4'hF, write PORT 8'hFF -> PORT reads 8'h0F, PIN reads 8'h0F; unmapped address reads 8'h00.
